fetch_queue: RTL and testbench

//  Parametrised instruction-fetch stage with a prefetch queue. Holds the fetch PC and issues

---
 rtl/fetch_queue_if.sv | 24 ++
 rtl/fetch_queue.sv | 115 +++++++++++
 tb/tb_fetch_queue.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle.
// Fetch drives the head instruction; decode drives ready.
interface fetch_queue_if #(
    parameter int PC_W = 32
) ();
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst_data;
    logic [PC_W-1:0] inst_pc;

    modport master (
        output inst_valid,
        output inst_data,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  inst_valid,
        input  inst_data,
        input  inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage with a credit-based prefetch queue.
// Redirects from decode (jump) and EX (branch) flush queued and in-flight fetches.
module fetch_queue #(
    parameter int              PC_W     = 32,
    parameter int              IMEM_AW  = 6,
    parameter int              QDEPTH   = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               flush_n,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               jump_id,
    input  logic [PC_W-1:0]    jump_pc_id,
    input  logic [25:0]        jump_tgt_id,
    input  logic               branch_taken_ex,
    input  logic [PC_W-1:0]    branch_tgt_ex,
    fetch_queue_if.master      dq
);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] DEPTH = (PW+1)'(QDEPTH);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     data;
    } entry_t;

    entry_t          q [QDEPTH];
    logic [PC_W-1:0] fpc;
    logic [PC_W-1:0] inflightPc;
    logic            inflight;
    logic [PW:0]     count;
    logic [PW-1:0]   rdPtr;
    logic [PW-1:0]   wrPtr;

    logic            redirect;
    logic            issue;
    logic            push;
    logic            pop;
    logic            valid;
    logic [PC_W-1:0] jumpPlus4;
    logic [PC_W-1:0] jumpTgt;
    logic [PC_W-1:0] target;

    assign redirect = branch_taken_ex | jump_id;
    assign valid    = (count != '0);
    // Credits cover both queued entries and the response still in flight.
    assign issue = flush_n & ~redirect
                 & ((count + {{PW{1'b0}}, inflight}) < DEPTH);
    assign push  = inflight & ~redirect;
    assign pop   = valid & dq.inst_ready & ~redirect;

    assign jumpPlus4 = jump_pc_id + PC_W'(4);

    generate
        if (PC_W > 28) begin : gWide
            logic unusedLow;
            assign jumpTgt   = {jumpPlus4[PC_W-1:28], jump_tgt_id, 2'b00};
            assign unusedLow = ^jumpPlus4[27:0];
        end else begin : gNarrow
            logic [27:0] full;
            logic        unusedHi;
            assign full     = {jump_tgt_id, 2'b00};
            assign jumpTgt  = full[PC_W-1:0];
            assign unusedHi = ^{jumpPlus4, full};
        end
    endgenerate

    always_comb begin
        target      = branch_taken_ex ? branch_tgt_ex : jumpTgt;
        target[1:0] = 2'b00;
    end

    always_ff @(posedge clk or negedge flush_n) begin
        if (!flush_n) begin
            fpc        <= RESET_PC;
            inflight   <= 1'b0;
            inflightPc <= '0;
            count      <= '0;
            rdPtr      <= '0;
            wrPtr      <= '0;
        end else if (redirect) begin
            fpc      <= target;
            inflight <= 1'b0;
            count    <= '0;
            rdPtr    <= '0;
            wrPtr    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fpc        <= fpc + PC_W'(4);
                inflightPc <= fpc;
            end
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage holds no reset; count alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (push) q[wrPtr] <= '{pc: inflightPc, data: imem_rdata};
    end

    assign imem_req      = issue;
    assign imem_addr     = fpc[IMEM_AW+1:2];
    assign dq.inst_valid = valid;
    assign dq.inst_data  = valid ? q[rdPtr].data : '0;
    assign dq.inst_pc    = valid ? q[rdPtr].pc : '0;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, redirects,
// PC wrap and asynchronous reset.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        flush_n;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        jump_id;
    logic [31:0] jump_pc_id;
    logic [25:0] jump_tgt_id;
    logic        branch_taken_ex;
    logic [31:0] branch_tgt_ex;
    logic [31:0] imem [64];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_queue_if #(.PC_W(32)) dq ();

    fetch_queue #(
        .PC_W    (32),
        .IMEM_AW (6),
        .QDEPTH  (4),
        .RESET_PC(32'h0)
    ) dut (
        .clk            (clk),
        .flush_n        (flush_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .jump_id        (jump_id),
        .jump_pc_id     (jump_pc_id),
        .jump_tgt_id    (jump_tgt_id),
        .branch_taken_ex(branch_taken_ex),
        .branch_tgt_ex  (branch_tgt_ex),
        .dq             (dq)
    );

    always @(posedge clk) imem_rdata <= imem[imem_addr];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h1000_0000 + i;
        flush_n         = 1'b0;
        dq.inst_ready   = 1'b1;
        jump_id         = 1'b0;
        jump_pc_id      = '0;
        jump_tgt_id     = '0;
        branch_taken_ex = 1'b0;
        branch_tgt_ex   = '0;
        tick();
        tick();

        chk("rst_valid", 64'(dq.inst_valid), 64'h0);
        chk("rst_data", 64'(dq.inst_data), 64'h0);
        chk("rst_pc", 64'(dq.inst_pc), 64'h0);
        chk("rst_req", 64'(imem_req), 64'h0);

        // streaming from RESET_PC
        flush_n = 1'b1;
        #1;
        chk("rel_req", 64'(imem_req), 64'h1);
        chk("rel_addr", 64'(imem_addr), 64'h0);
        tick();
        chk("lat1_valid", 64'(dq.inst_valid), 64'h0);
        tick();
        chk("lat2_valid", 64'(dq.inst_valid), 64'h1);
        for (int k = 0; k < 6; k++) begin
            chk("strm_pc", 64'(dq.inst_pc), 64'(4 * k));
            chk("strm_data", 64'(dq.inst_data), 64'(32'h1000_0000 + k));
            if (k < 5) tick();
        end

        // backpressure: queue fills to 4, requests stop
        dq.inst_ready = 1'b0;
        repeat (10) tick();
        chk("full_req", 64'(imem_req), 64'h0);
        chk("full_valid", 64'(dq.inst_valid), 64'h1);
        dq.inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("drain_valid", 64'(dq.inst_valid), 64'h1);
            chk("drain_pc", 64'(dq.inst_pc), 64'(20 + 4 * k));
            if (k < 5) tick();
        end

        // branch with 3 queued and 1 in flight
        dq.inst_ready = 1'b0;
        tick();
        branch_taken_ex = 1'b1;
        branch_tgt_ex   = 32'h40;
        #1;
        chk("br_req", 64'(imem_req), 64'h0);
        tick();
        branch_taken_ex = 1'b0;
        dq.inst_ready   = 1'b1;
        #1;
        chk("br_t1_valid", 64'(dq.inst_valid), 64'h0);
        chk("br_t1_req", 64'(imem_req), 64'h1);
        chk("br_t1_addr", 64'(imem_addr), 64'h10);
        tick();
        chk("br_t2_valid", 64'(dq.inst_valid), 64'h0);
        tick();
        chk("br_t3_valid", 64'(dq.inst_valid), 64'h1);
        chk("br_t3_pc", 64'(dq.inst_pc), 64'h40);
        chk("br_t3_data", 64'(dq.inst_data), 64'h1000_0010);

        // jump and branch together: branch wins
        jump_id         = 1'b1;
        jump_pc_id      = 32'h100;
        jump_tgt_id     = 26'h20;
        branch_taken_ex = 1'b1;
        branch_tgt_ex   = 32'h20;
        tick();
        jump_id         = 1'b0;
        branch_taken_ex = 1'b0;
        #1;
        chk("both_t1_valid", 64'(dq.inst_valid), 64'h0);
        tick();
        tick();
        chk("both_pc", 64'(dq.inst_pc), 64'h20);
        chk("both_data", 64'(dq.inst_data), 64'h1000_0008);

        // jump target with upper PC bits, then wrap
        jump_id     = 1'b1;
        jump_pc_id  = 32'hF000_0010;
        jump_tgt_id = 26'h3FF_FFFF;
        tick();
        jump_id = 1'b0;
        tick();
        tick();
        chk("jmp_pc", 64'(dq.inst_pc), 64'hFFFF_FFFC);
        chk("jmp_data", 64'(dq.inst_data), 64'h1000_003F);
        tick();
        chk("wrap_pc", 64'(dq.inst_pc), 64'h0);
        chk("wrap_data", 64'(dq.inst_data), 64'h1000_0000);

        // asynchronous reset mid-stream
        #2;
        flush_n = 1'b0;
        #1;
        chk("arst_valid", 64'(dq.inst_valid), 64'h0);
        chk("arst_pc", 64'(dq.inst_pc), 64'h0);
        chk("arst_data", 64'(dq.inst_data), 64'h0);
        chk("arst_req", 64'(imem_req), 64'h0);
        tick();
        flush_n = 1'b1;
        tick();
        chk("rst2_valid", 64'(dq.inst_valid), 64'h0);
        tick();
        chk("rst2_pc0", 64'(dq.inst_pc), 64'h0);
        chk("rst2_valid1", 64'(dq.inst_valid), 64'h1);
        tick();
        chk("rst2_pc4", 64'(dq.inst_pc), 64'h4);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
